// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 decryption sequencer: one inverse round per clock over a single state register,
// with round keys fetched by index from an external key store and valid/ready on both sides.
module aes_inv_cipher_ctrl #(
  parameter int unsigned NR    = 10,
  parameter int unsigned RKI_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic             key_ready,
  output logic [RKI_W-1:0] rk_idx,
  input  logic [127:0]     rk_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             busy,
  input  logic             flush
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRound = 2'd1;
  localparam logic [1:0] StFinal = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(a, a);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
    logic [7:0] x;
    x = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(x);
  endfunction

  // Byte k sits at [127-8k -: 8]; row r = k % 4, column c = k / 4.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = inv_sub_byte(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = gf_mul(a[r], 8'h0e) ^ gf_mul(a[(r+1)%4], 8'h0b) ^
                                gf_mul(a[(r+2)%4], 8'h0d) ^ gf_mul(a[(r+3)%4], 8'h09);
      end
    end
    return o;
  endfunction

  logic [1:0]       fsm_q, fsm_d;
  logic [127:0]     state_q, state_d;
  logic [RKI_W-1:0] rnd_q, rnd_d;
  logic [127:0]     out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [127:0]     keyed;
  logic [127:0]     round_out;

  always_comb begin
    keyed     = inv_shift_sub(state_q) ^ rk_in;
    round_out = inv_mix_columns(keyed);
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rnd_d       = rnd_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      // Scrub everything key-mixed, including any pending plaintext.
      fsm_d       = StIdle;
      state_d     = '0;
      rnd_d       = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
    end else begin
      case (fsm_q)
        StIdle: begin
          if (in_valid && key_ready) begin
            state_d = in_data ^ rk_in;
            rnd_d   = RKI_W'(NR - 1);
            fsm_d   = StRound;
          end
        end
        StRound: begin
          if (key_ready) begin
            state_d = round_out;
            rnd_d   = rnd_q - 1'b1;
            if (rnd_q == RKI_W'(1)) fsm_d = StFinal;
          end
        end
        StFinal: begin
          if (key_ready) begin
            out_data_d  = keyed;
            out_valid_d = 1'b1;
            fsm_d       = StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            fsm_d       = StIdle;
          end
        end
        default: fsm_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= StIdle;
      state_q     <= '0;
      rnd_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    case (fsm_q)
      StIdle:  rk_idx = RKI_W'(NR);
      StRound: rk_idx = rnd_q;
      default: rk_idx = '0;
    endcase
  end

  assign in_ready  = (fsm_q == StIdle) && key_ready;
  assign busy      = (fsm_q == StRound) || (fsm_q == StFinal);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
